// File: rtl/mxint8_dot_product_pkg.sv
// Shared constants and FSM encoding for the MXINT8 dot-product datapath.
// Scales are E8M0 (bias 127, 0xFF = NaN); elements are 8-bit two's complement.
package mxint8_dot_product_pkg;

  localparam int BLOCK_SIZE           = 32;
  localparam int LANES                = 4;
  localparam int SCALE_WIDTH          = 8;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int SCALE_BIAS           = 127;
  localparam logic [SCALE_WIDTH-1:0] SCALE_NAN = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxint8_lane_mac.sv
// Combinational multiply stage: LANES signed 8x8 products summed into one
// partial sum wide enough that the lane additions can never overflow.
module mxint8_lane_mac #(
  parameter int LANES      = 4,
  parameter int ELEM_WIDTH = 8
) (
  input  logic        [LANES*ELEM_WIDTH-1:0]           i_a,
  input  logic        [LANES*ELEM_WIDTH-1:0]           i_b,
  output logic signed [2*ELEM_WIDTH+$clog2(LANES)-1:0] o_psum
);
  import mxint8_dot_product_pkg::*;

  localparam int PROD_W = 2 * ELEM_WIDTH;
  localparam int PSUM_W = PROD_W + $clog2(LANES);

  logic signed [PROD_W-1:0] w_prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_prod[gi] = $signed(i_a[gi*ELEM_WIDTH +: ELEM_WIDTH])
                      * $signed(i_b[gi*ELEM_WIDTH +: ELEM_WIDTH]);
  end

  always_comb begin
    o_psum = '0;
    for (int i = 0; i < LANES; i++) begin
      o_psum = o_psum + PSUM_W'(w_prod[i]);
    end
  end

endmodule

// File: rtl/mxint8_dot_product.sv
// MXINT8 block dot product: captures an A/B block pair, accumulates LANES
// products per cycle, then holds the exact sum and combined exponent until taken.
module mxint8_dot_product #(
  parameter int BLOCK_SIZE  = mxint8_dot_product_pkg::BLOCK_SIZE,
  parameter int LANES       = mxint8_dot_product_pkg::LANES,
  parameter int ELEM_WIDTH  = mxint8_dot_product_pkg::MXINT8_ELEMENT_WIDTH,
  parameter int SCALE_WIDTH = mxint8_dot_product_pkg::SCALE_WIDTH,
  parameter int ACC_WIDTH   = 2*ELEM_WIDTH + $clog2(BLOCK_SIZE)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [SCALE_WIDTH-1:0]       i_a_scale,
  input  logic [SCALE_WIDTH-1:0]       i_b_scale,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_a_elements,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0] i_b_elements,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [ACC_WIDTH-1:0]         o_acc,
  output logic [SCALE_WIDTH+1:0]       o_exp,
  output logic                         o_nan
);
  import mxint8_dot_product_pkg::*;

  localparam int BEATS     = BLOCK_SIZE / LANES;
  localparam int CNT_W     = cnt_width(BEATS);
  localparam int LANE_BITS = LANES * ELEM_WIDTH;
  localparam int BLK_BITS  = BLOCK_SIZE * ELEM_WIDTH;
  localparam int PSUM_W    = 2*ELEM_WIDTH + $clog2(LANES);
  localparam int EXP_W     = SCALE_WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [EXP_W-1:0] EXP_OFFSET = EXP_W'(2 * SCALE_BIAS);

  state_e                       r_state;
  state_e                       w_state_next;
  logic                         w_ready;
  logic                         w_valid;
  logic                         w_accept;
  logic                         w_last;
  logic [CNT_W-1:0]             r_cnt;
  logic [BLK_BITS-1:0]          r_a_elems;
  logic [BLK_BITS-1:0]          r_b_elems;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  r_result;
  logic [EXP_W-1:0]             r_exp;
  logic                         r_nan;
  logic signed [PSUM_W-1:0]     w_psum;
  logic signed [ACC_WIDTH-1:0]  w_acc_sum;
  logic [EXP_W-1:0]             w_exp;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_valid      = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (i_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        if (r_cnt == LAST_BEAT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Ready stays low here, so a new block is never taken in the release cycle.
        w_valid = 1'b1;
        if (i_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  mxint8_lane_mac #(
    .LANES      (LANES),
    .ELEM_WIDTH (ELEM_WIDTH)
  ) u_lane_mac (
    .i_a    (r_a_elems[LANE_BITS-1:0]),
    .i_b    (r_b_elems[LANE_BITS-1:0]),
    .o_psum (w_psum)
  );

  assign w_acc_sum = r_acc + ACC_WIDTH'(w_psum);
  assign w_exp     = {2'b00, i_a_scale} + {2'b00, i_b_scale} - EXP_OFFSET;

  // Element registers shift down one beat per cycle so the lanes always read the low slice.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_exp     <= '0;
      r_nan     <= 1'b0;
      r_a_elems <= '0;
      r_b_elems <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_exp     <= w_exp;
      r_nan     <= (i_a_scale == SCALE_NAN) || (i_b_scale == SCALE_NAN);
      r_a_elems <= i_a_elements;
      r_b_elems <= i_b_elements;
    end else if (r_state == ST_MAC) begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_acc     <= w_acc_sum;
      r_a_elems <= r_a_elems >> LANE_BITS;
      r_b_elems <= r_b_elems >> LANE_BITS;
      if (w_last) begin
        r_result <= w_acc_sum;
      end
    end
  end

  assign o_ready = w_ready;
  assign o_valid = w_valid;
  assign o_acc   = r_result;
  assign o_exp   = r_exp;
  assign o_nan   = r_nan;

endmodule

// File: tb/tb_mxint8_dot_product.sv
// Randomised bench for mxint8_dot_product: a plain-arithmetic dot-product model
// predicts acc/exp/nan for each block and the handshake timing is checked per block.
module tb_mxint8_dot_product;

  localparam int BS    = 32;
  localparam int EW    = 8;
  localparam int SW    = 8;
  localparam int AW    = 21;
  localparam int BEATS = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [SW-1:0]     i_a_scale;
  logic [SW-1:0]     i_b_scale;
  logic [BS*EW-1:0]  i_a_elements;
  logic [BS*EW-1:0]  i_b_elements;
  logic              o_valid;
  logic              i_ready;
  logic [AW-1:0]     o_acc;
  logic [SW+1:0]     o_exp;
  logic              o_nan;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int blk_id   = 0;
  int a_el [BS];
  int b_el [BS];
  int exp_acc_q [$];
  int exp_exp_q [$];
  int exp_nan_q [$];
  int hs_cyc_q  [$];

  mxint8_dot_product dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_a_scale    (i_a_scale),
    .i_b_scale    (i_b_scale),
    .i_a_elements (i_a_elements),
    .i_b_elements (i_b_elements),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_acc        (o_acc),
    .o_exp        (o_exp),
    .o_nan        (o_nan)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (blk %0d)", tag, obs, expv, blk_id);
    end
  endtask

  task automatic drive_inputs(input int sa, input int sb);
    for (int k = 0; k < BS; k++) begin
      i_a_elements[k*EW +: EW] = 8'(a_el[k]);
      i_b_elements[k*EW +: EW] = 8'(b_el[k]);
    end
    i_a_scale = SW'(sa);
    i_b_scale = SW'(sb);
    i_valid   = 1'b1;
  endtask

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic send_block(input int sa, input int sb);
    bit done = 1'b0;
    int dot  = 0;
    drive_inputs(sa, sb);
    for (int t = 0; t < 40 && !done; t++) begin
      if (o_ready === 1'b1) begin
        @(posedge i_clk);
        done = 1'b1;
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    if (!done) begin
      check("handshake_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < BS; k++) dot += a_el[k] * b_el[k];
    exp_acc_q.push_back(dot);
    exp_exp_q.push_back(sa + sb - 254);
    exp_nan_q.push_back((sa == 255 || sb == 255) ? 1 : 0);
    hs_cyc_q.push_back(cyc);
  endtask

  task automatic finish_block(input int hold);
    bit seen = 1'b0;
    int e_acc, e_exp, e_nan, hs;
    if (exp_acc_q.size() == 0) return;
    e_acc = exp_acc_q.pop_front();
    e_exp = exp_exp_q.pop_front();
    e_nan = exp_nan_q.pop_front();
    hs    = hs_cyc_q.pop_front();
    for (int t = 0; t < 40 && !seen; t++) begin
      if (o_valid === 1'b1) seen = 1'b1;
      else @(negedge i_clk);
    end
    if (!seen) begin
      check("valid_timeout", 0, 1);
      return;
    end
    check("latency", cyc - hs, BEATS);
    check("acc", $signed(o_acc), e_acc);
    check("exp", $signed(o_exp), e_exp);
    check("nan", o_nan, e_nan);
    check("ready_in_done", o_ready, 0);
    $display("blk %0d: acc=%0d exp=%0d nan=%0d latency=%0d hold=%0d",
             blk_id, $signed(o_acc), $signed(o_exp), o_nan, cyc - hs, hold);
    repeat (hold) begin
      @(negedge i_clk);
      check("hold_valid", o_valid, 1);
      check("hold_acc", $signed(o_acc), e_acc);
      check("hold_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check("valid_drop", o_valid, 0);
    blk_id++;
  endtask

  task automatic rand_elems();
    for (int k = 0; k < BS; k++) begin
      a_el[k] = int'($urandom_range(0, 255)) - 128;
      b_el[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sa2, sb2;
    bit saw;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a_scale = '0; i_b_scale = '0; i_a_elements = '0; i_b_elements = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_acc", $signed(o_acc), 0);
    check("rst_exp", $signed(o_exp), 0);
    check("rst_nan", o_nan, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // 1.0 * 1.0 over the whole block
    for (int k = 0; k < BS; k++) begin a_el[k] = 64; b_el[k] = 64; end
    send_block(127, 127);
    finish_block(0);

    // worst-case magnitude, must not wrap
    for (int k = 0; k < BS; k++) begin a_el[k] = -128; b_el[k] = -128; end
    send_block(130, 120);
    finish_block(1);

    // ramp against ones
    for (int k = 0; k < BS; k++) begin a_el[k] = k - 16; b_el[k] = 1; end
    send_block(127, 127);
    finish_block(0);

    // NaN scale
    rand_elems();
    send_block(255, 127);
    finish_block(0);

    // back-pressure with the next block already waiting
    rand_elems();
    send_block(int'($urandom_range(0, 254)), int'($urandom_range(0, 254)));
    rand_elems();
    sa2 = int'($urandom_range(0, 255));
    sb2 = int'($urandom_range(0, 255));
    drive_inputs(sa2, sb2);
    finish_block(5);
    send_block(sa2, sb2);
    finish_block(0);

    // reset in the middle of accumulation
    rand_elems();
    send_block(100, 150);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_acc_q.delete(); exp_exp_q.delete(); exp_nan_q.delete(); hs_cyc_q.delete();
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_acc", $signed(o_acc), 0);
    saw = 1'b0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) saw = 1'b1;
    end
    check("midrst_no_pulse", saw, 0);
    rand_elems();
    send_block(127, 130);
    finish_block(0);

    // random traffic
    for (int n = 0; n < 12; n++) begin
      rand_elems();
      sa2 = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
      sb2 = int'($urandom_range(0, 255));
      send_block(sa2, sb2);
      finish_block(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mxint8_dot_product.md
Name: mxint8_dot_product

Overview:
- Downstream consumer of MXINT8 blocks: one shared scale plus BLOCK_SIZE 8-bit two's-complement elements.
- Takes two MXINT8 blocks (A, B) and computes their dot product as an exact integer accumulator plus a combined unbiased exponent.
- Processes LANES element pairs per cycle under a valid/ready handshake on both input and output.
- Feeds the float32 re-normalisation stage of the MX ALU.

Parameters:
- BLOCK_SIZE, 32, elements per MX block; must be a multiple of LANES.
- LANES, 4, multiply lanes per cycle.
- ELEM_WIDTH, 8, MXINT8 element width (1 sign bit, 1 integer bit, 6 fraction bits).
- SCALE_WIDTH, 8, E8M0 shared scale width, bias 127.
- ACC_WIDTH, 2*ELEM_WIDTH + clog2(BLOCK_SIZE) = 21, signed accumulator width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  input block pair is valid.
- o_ready  out  1  block accepts input.
- i_a_scale  in  SCALE_WIDTH  shared scale of block A.
- i_b_scale  in  SCALE_WIDTH  shared scale of block B.
- i_a_elements  in  BLOCK_SIZE*ELEM_WIDTH  A elements, flattened; element k is at bits [k*8+7:k*8].
- i_b_elements  in  BLOCK_SIZE*ELEM_WIDTH  B elements, same packing.
- o_valid  out  1  result is valid.
- i_ready  in  1  downstream accepts the result.
- o_acc  out  ACC_WIDTH  signed sum of a_k*b_k; LSB weight is 2^-12.
- o_exp  out  SCALE_WIDTH+2  signed a_scale + b_scale - 254.
- o_nan  out  1  either scale equals 0xFF.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state goes to IDLE; counter and accumulator clear.
  - o_valid=0, o_acc=0, o_exp=0, o_nan=0.
  - o_ready is 1 in the first cycle after reset.
  - Reset takes priority over every other event, including mid-MAC and mid-DONE; any partial result is discarded and no o_valid pulse is produced.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid && o_ready: capture both scales and all elements into internal registers, clear acc and beat counter, go to MAC.
  - Inputs are don't-care after the handshake.
- MAC:
  - o_ready=0.
  - Each cycle: acc += sum over lanes j of sext(a[cnt*LANES+j]) * sext(b[cnt*LANES+j]).
  - Products are 16-bit signed and are sign-extended to ACC_WIDTH before summing.
  - cnt increments by 1 per cycle. When cnt == BLOCK_SIZE/LANES-1, write the final sum and go to DONE.
  - MAC lasts exactly BLOCK_SIZE/LANES cycles (8 at the defaults).
- DONE:
  - o_valid=1; o_acc, o_exp and o_nan are stable and held until i_ready=1.
  - On o_valid && i_ready: go to IDLE at the next edge, o_valid drops.
  - o_ready stays 0 in DONE, so no same-cycle accept-and-release.
- Latency and throughput:
  - Input handshake at edge t gives o_valid=1 from edge t+BLOCK_SIZE/LANES (t+8 at the defaults).
  - Maximum throughput is one block pair per BLOCK_SIZE/LANES+1 cycles, with i_ready tied high.
- Arithmetic:
  - ACC_WIDTH is sized so no overflow is possible. The worst case is 32*(-128*-128) = 524288 = 2^19, which fits in 21-bit signed.
  - o_exp = zext(a_scale) + zext(b_scale) - 254, in 10-bit signed; range -254..254.
- NaN:
  - o_nan = (a_scale==8'hFF) || (b_scale==8'hFF), registered at capture.
  - o_acc is still computed when o_nan=1; downstream ignores it.
- Zero elements and zero scales (0x00, value 2^-127) are treated arithmetically; there is no special case.
- Outputs change only on state transitions; they are not combinational from the inputs.

Decomposition:
- The shared include / package holds:
  - BLOCK_SIZE, SCALE_WIDTH, MXINT8_ELEMENT_WIDTH;
  - SCALE_BIAS=127 and SCALE_NAN=8'hFF;
  - the FSM state encodings.
- One sub-module: mxint8_lane_mac.
  - Combinational: LANES signed 8x8 multipliers plus an adder tree.
  - Output is a (2*ELEM_WIDTH+clog2(LANES))-bit partial sum.
  - Instantiated once. The FSM, counter, accumulator and handshake stay in the top module.

Test Plan:
1. All A elements = 8'h40 (1.0), all B elements = 8'h40, scales 127/127 -> o_acc = 32*4096 = 131072, o_exp = 0, o_nan = 0; o_valid first high 8 cycles after the handshake.
2. A elements = 8'h80 (-2.0), B elements = 8'h80, scales 130/120 -> o_acc = 524288 (no wrap), o_exp = -4.
3. A element k = k-16, B elements all 8'h01, scales 127/127 -> o_acc = -16.
4. a_scale = 8'hFF, b_scale = 127, any elements -> o_nan = 1; o_exp = 128.
5. i_ready held low for 5 cycles in DONE while i_valid is held high with new data -> o_valid and o_acc are stable, o_ready = 0; the second block is accepted only after the output handshake, and its result is correct.
6. i_rst_n asserted low for 1 cycle at MAC beat 3 -> the next cycle has o_valid = 0, o_ready = 1, o_acc = 0; a following fresh block gives the correct result with no stale accumulation.
